// File: rtl/shift_add_multiplier_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_multiplier_pkg
//  Description : Shared constants for the shift-add multiplier: controller
//                state encoding, 2-bit datapath register command codes
//                (common with the restoring divider) and the counter width
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_add_multiplier_pkg;

    // Controller state encoding
    localparam int          STATE_W = 3;
    localparam logic [2:0]  S_IDLE  = 3'd0;
    localparam logic [2:0]  S_INIT  = 3'd1;
    localparam logic [2:0]  S_CALC  = 3'd2;
    localparam logic [2:0]  S_FIXUP = 3'd3;
    localparam logic [2:0]  S_DONE  = 3'd4;

    // Datapath register commands, same codes as the divider's datapath
    localparam int          CMD_W     = 2;
    localparam logic [1:0]  CMD_HOLD  = 2'd0;
    localparam logic [1:0]  CMD_LOAD  = 2'd1;
    localparam logic [1:0]  CMD_SHIFT = 2'd2;
    localparam logic [1:0]  CMD_ADD   = 2'd3;

    // Bit count register must hold the value WIDTH itself
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : shift_add_multiplier_pkg
`default_nettype wire

// File: rtl/shift_add_mul_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_mul_ctrl
//  Description : Controller for the shift-add multiplier. Sequences
//                IDLE -> INIT -> CALC (WIDTH cycles) [-> FIXUP] -> DONE and
//                issues hold/load/shift/add commands to the datapath.
//                FIXUP exists only when MUL_ADD_REMAINDER_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_mul_ctrl
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_got_result,
    input  logic             i_q0,
    output logic [CMD_W-1:0] o_cmd,
`ifdef MUL_ADD_REMAINDER_EN
    output logic             o_fixup,
`endif
    output logic             o_busy,
    output logic             o_done
);

    localparam int CNT_W = count_width(WIDTH);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [CNT_W-1:0]   r_count;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the last CALC cycle is the one where count is 1
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_INIT;
                end
            end
            S_INIT: begin
                w_next = S_CALC;
            end
            S_CALC: begin
                if (r_count == CNT_W'(1)) begin
`ifdef MUL_ADD_REMAINDER_EN
                    w_next = S_FIXUP;
`else
                    w_next = S_DONE;
`endif
                end
            end
`ifdef MUL_ADD_REMAINDER_EN
            S_FIXUP: begin
                w_next = S_DONE;
            end
`endif
            S_DONE: begin
                // gotResult has priority; a coincident start is re-sampled in IDLE
                if (i_got_result) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Bit counter: loaded on leaving INIT, decremented once per CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_state == S_INIT) begin
            r_count <= CNT_W'(WIDTH);
        end else if (r_state == S_CALC) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Output decode: commands and status flags from the current state
    always_comb begin
        o_cmd  = CMD_HOLD;
        o_busy = 1'b0;
        o_done = 1'b0;
`ifdef MUL_ADD_REMAINDER_EN
        o_fixup = 1'b0;
`endif
        case (r_state)
            S_INIT: begin
                o_cmd  = CMD_LOAD;
                o_busy = 1'b1;
            end
            S_CALC: begin
                o_cmd  = i_q0 ? CMD_ADD : CMD_SHIFT;
                o_busy = 1'b1;
            end
`ifdef MUL_ADD_REMAINDER_EN
            S_FIXUP: begin
                o_fixup = 1'b1;
                o_busy  = 1'b1;
            end
`endif
            S_DONE: begin
                o_done = 1'b1;
            end
            default: begin
                o_cmd = CMD_HOLD;
            end
        endcase
    end

endmodule : shift_add_mul_ctrl
`default_nettype wire

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : shift_add_multiplier
//  Description : Sequential unsigned shift-add multiplier, one multiplier bit
//                per cycle. product = {A,Q} = multiplier * multiplicand.
//                Define MUL_ADD_REMAINDER_EN to add a FIXUP cycle that adds
//                the zero-extended addend (Q*M+R reconstruction).
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               gotResult,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   addend,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [CMD_W-1:0] w_cmd;
    logic [WIDTH:0]   w_sum;   // {C,A} after the optional add
`ifdef MUL_ADD_REMAINDER_EN
    logic             w_fixup;
`else
    logic             w_unused_addend;
    assign w_unused_addend = ^addend;
`endif

    shift_add_mul_ctrl #(
        .WIDTH        (WIDTH)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .i_start      (start),
        .i_got_result (gotResult),
        .i_q0         (r_q[0]),
        .o_cmd        (w_cmd),
`ifdef MUL_ADD_REMAINDER_EN
        .o_fixup      (w_fixup),
`endif
        .o_busy       (busy),
        .o_done       (done)
    );

    // WIDTH+1-bit add of M into A when the current multiplier bit is set
    assign w_sum = {1'b0, r_a} + ((w_cmd == CMD_ADD) ? {1'b0, r_m} : '0);

    // A/Q/M registers: load operands, then shift {C,A,Q} right one bit per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_q <= '0;
            r_m <= '0;
        end else begin
`ifdef MUL_ADD_REMAINDER_EN
            if (w_fixup) begin
                {r_a, r_q} <= {r_a, r_q} + {{WIDTH{1'b0}}, addend};
            end else
`endif
            case (w_cmd)
                CMD_LOAD: begin
                    r_a <= '0;
                    r_q <= multiplier;
                    r_m <= multiplicand;
                end
                CMD_SHIFT, CMD_ADD: begin
                    r_a <= w_sum[WIDTH:1];
                    r_q <= {w_sum[0], r_q[WIDTH-1:1]};
                end
                default: begin
                    r_a <= r_a;
                end
            endcase
        end
    end

    assign product = {r_a, r_q};

endmodule : shift_add_multiplier
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_add_multiplier
//  Description : Self-checking bench for shift_add_multiplier. Honours
//                MUL_ADD_REMAINDER_EN for expected results and latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

    localparam int W = 5;
`ifdef MUL_ADD_REMAINDER_EN
    localparam bit ADD_EN = 1'b1;
`else
    localparam bit ADD_EN = 1'b0;
`endif
    // Edges after the start-sampling edge until done is visible
    localparam int LAT = W + 1 + (ADD_EN ? 1 : 0);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           gotResult = 1'b0;
    logic [W-1:0]   mr = '0;
    logic [W-1:0]   md = '0;
    logic [W-1:0]   ad = '0;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    int             n_cmp = 0;
    int             n_fail = 0;
    logic [2*W-1:0] exp_prod = '0;
    bit             hold_chk = 1'b0;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .gotResult    (gotResult),
        .multiplier   (mr),
        .multiplicand (md),
        .addend       (ad),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic result of one operation
    function automatic logic [2*W-1:0] model(input int a, input int b, input int c);
        int r;
        r = a * b + (ADD_EN ? c : 0);
        return r[2*W-1:0];
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle the result is meaningful (DONE, or IDLE after it) check it
    always @(negedge clk) begin
        if (!rst && (done || hold_chk)) begin
            chk("product_vs_model", product, exp_prod);
            if (done) chk("busy_low_in_done", busy, 0);
        end
    end

    task automatic run_op(input int a, input int b, input int c, input int hold,
                          input bit poke_start, input bit both_high);
        int cyc;
        @(posedge clk); #1;
        mr = a[W-1:0]; md = b[W-1:0]; ad = c[W-1:0];
        start = 1'b1; hold_chk = 1'b0;
        exp_prod = model(a, b, c);
        @(posedge clk); #1;          // start sampled on this edge
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < LAT + 5) begin
            chk("busy_while_running", busy, 1);
            @(posedge clk); #1;
            cyc++;
            start = poke_start && (cyc == 2);
        end
        start = 1'b0;
        chk("latency", cyc, LAT);
        chk("done_high", done, 1);
        repeat (hold) @(posedge clk);
        #1;
        gotResult = 1'b1;
        start = both_high;
        @(posedge clk); #1;
        gotResult = 1'b0;
        start = 1'b0;
        chk("done_cleared", done, 0);
        chk("idle_not_busy", busy, 0);
        hold_chk = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("no_restart", busy, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        chk("reset_product", product, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(3, 5, 0, 0, 1'b0, 1'b0);
        chk("lit_3x5", product, 15);
        run_op(31, 31, 0, 10, 1'b0, 1'b0);
        chk("lit_31x31", product, 961);
        run_op(0, 17, 9, 1, 1'b1, 1'b0);
        chk("lit_0x17", product, ADD_EN ? 9 : 0);
        run_op(17, 0, 0, 1, 1'b1, 1'b0);
        chk("lit_17x0", product, 0);

        // Asynchronous reset in the middle of CALC
        @(posedge clk); #1;
        mr = 5'd9; md = 5'd7; ad = '0; start = 1'b1; hold_chk = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_product", product, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(9, 7, 0, 0, 1'b0, 1'b0);
        chk("lit_9x7", product, 63);

        run_op(6, 5, 4, 0, 1'b0, 1'b0);
        chk("lit_6x5p4", product, ADD_EN ? 34 : 30);
        run_op(31, 31, 31, 0, 1'b0, 1'b0);
        chk("lit_31x31p31", product, ADD_EN ? 992 : 961);
        run_op(14, 7, 2, 0, 1'b0, 1'b0);
        chk("lit_loopback", product, ADD_EN ? 100 : 98);

        // start and gotResult together in DONE: must return to IDLE only
        run_op(12, 11, 3, 2, 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            run_op($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 3), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_shift_add_multiplier
`default_nettype wire
